// File: rtl/bmem_pkg.sv
// Shared types and constants for the CPU-side banked-memory line adapter.
package bmem_pkg;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = BEAT_W * BEATS;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        DONE
    } adapter_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    // Round-robin choice when both caches read: the side not served last wins.
    function automatic grant_t rr_pick(input grant_t last);
        return (last == GNT_D) ? GNT_I : GNT_D;
    endfunction

endpackage

// File: rtl/bmem_line_buffer.sv
// Beat register file with a beat index, shared by the read (assemble) and
// write (load then shift out) paths of the line adapter.
module bmem_line_buffer #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      clear,
    input  logic                      store,
    input  logic                      step,
    input  logic [BEAT_W*BEATS-1:0]   line_in,
    input  logic [BEAT_W-1:0]         beat_in,
    output logic [BEAT_W-1:0]         beat_out,
    output logic [BEAT_W*BEATS-1:0]   line_out,
    output logic                      last
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0] beats [BEATS];
    logic [CNT_W-1:0]  cnt;

    assign last     = (cnt == CNT_W'(BEATS - 1));
    assign beat_out = beats[cnt];

    // NOTE: sequential state is written with <= only, so every register in
    // this block samples the pre-edge values regardless of statement order.
    // NOTE: the beat storage is reset because it drives the rdata outputs,
    // which must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                beats[i] <= '0;
            end
            cnt <= '0;
        end else if (load) begin
            for (int i = 0; i < BEATS; i++) begin
                beats[i] <= line_in[i*BEAT_W +: BEAT_W];
            end
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (store || step) begin
            if (store) begin
                beats[cnt] <= beat_in;
            end
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line_out[g*BEAT_W +: BEAT_W] = beats[g];
    end

endmodule

// File: rtl/bmem_line_adapter.sv
// Arbitrates icache/dcache line misses onto a single 4-beat bmem burst port.
// Optional build macro BMEM_RADDR_CHECK_EN enables the sticky prot_err check.
module bmem_line_adapter #(
    parameter int ADDR_W = bmem_pkg::ADDR_W,
    parameter int BEAT_W = bmem_pkg::BEAT_W,
    parameter int BEATS  = bmem_pkg::BEATS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     i_read,
    output logic [BEAT_W*BEATS-1:0]  i_rdata,
    output logic                     i_resp,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic                     d_read,
    input  logic                     d_write,
    input  logic [BEAT_W*BEATS-1:0]  d_wdata,
    output logic [BEAT_W*BEATS-1:0]  d_rdata,
    output logic                     d_resp,
    output logic [ADDR_W-1:0]        bmem_addr,
    output logic                     bmem_read,
    output logic                     bmem_write,
    output logic [BEAT_W-1:0]        bmem_wdata,
    input  logic                     bmem_ready,
    input  logic [ADDR_W-1:0]        bmem_raddr,
    input  logic [BEAT_W-1:0]        bmem_rdata,
    input  logic                     bmem_rvalid,
    output logic                     prot_err
);

    import bmem_pkg::*;

    localparam int OFF_W = $clog2(BEAT_W * BEATS / 8);

    adapter_state_t state_q, state_d;
    grant_t         grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic buf_load, buf_clear, buf_store, buf_step, buf_last;
    logic [BEAT_W-1:0]       buf_beat;
    logic [BEAT_W*BEATS-1:0] buf_line;

    logic [ADDR_W-1:0] i_line_addr, d_line_addr;
    assign i_line_addr = {i_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign d_line_addr = {d_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

    bmem_line_buffer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .store    (buf_store),
        .step     (buf_step),
        .line_in  (d_wdata),
        .beat_in  (bmem_rdata),
        .beat_out (buf_beat),
        .line_out (buf_line),
        .last     (buf_last)
    );

    assign i_rdata = buf_line;
    assign d_rdata = buf_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= GNT_D;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        buf_store  = 1'b0;
        buf_step   = 1'b0;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A writeback (even with d_read also high) beats any read.
                if (d_write) begin
                    grant_d  = GNT_D;
                    addr_d   = d_line_addr;
                    buf_load = 1'b1;
                    state_d  = WR_BURST;
                end else if (i_read || d_read) begin
                    if (i_read && d_read) begin
                        grant_d = rr_pick(grant_q);
                    end else begin
                        grant_d = i_read ? GNT_I : GNT_D;
                    end
                    addr_d    = (grant_d == GNT_I) ? i_line_addr : d_line_addr;
                    buf_clear = 1'b1;
                    state_d   = RD_REQ;
                end
            end

            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                if (bmem_rvalid) begin
                    buf_store = 1'b1;
                    if (buf_last) begin
                        state_d = DONE;
                    end
                end
            end

            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = buf_beat;
                if (bmem_ready) begin
                    buf_step = 1'b1;
                    if (buf_last) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                i_resp  = (grant_q == GNT_I);
                d_resp  = (grant_q == GNT_D);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BMEM_RADDR_CHECK_EN
    logic prot_err_q;

    // Stray or mis-tagged read data is flagged but never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prot_err_q <= 1'b0;
        end else if (bmem_rvalid && (state_q != RD_DATA || bmem_raddr != addr_q)) begin
            prot_err_q <= 1'b1;
        end
    end

    assign prot_err = prot_err_q;

    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};
`else
    assign prot_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{bmem_raddr, i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};
`endif

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed self-checking bench for bmem_line_adapter (default or
// BMEM_RADDR_CHECK_EN build).
module tb_bmem_line_adapter;

`ifdef BMEM_RADDR_CHECK_EN
    localparam logic FEAT = 1'b1;
`else
    localparam logic FEAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         prot_err;

    int n_checks = 0;
    int n_fail   = 0;

    int i_resp_cnt  = 0;
    int d_resp_cnt  = 0;
    int rd_cmd_cnt  = 0;
    logic [63:0] acc_q[$];

    always #5 clk = ~clk;

    bmem_line_adapter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .prot_err    (prot_err)
    );

    always @(posedge clk) begin
        if (i_resp) i_resp_cnt <= i_resp_cnt + 1;
        if (d_resp) d_resp_cnt <= d_resp_cnt + 1;
        if (bmem_read) rd_cmd_cnt <= rd_cmd_cnt + 1;
        if (bmem_write && bmem_ready) acc_q.push_back(bmem_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts in an IDLE cycle with the request already raised.
    task automatic read_line(input logic exp_i, input logic [31:0] exp_addr,
                             input logic [63:0] base, input logic bad_raddr,
                             input logic rearm);
        logic [255:0] exp_line;
        for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = base + 64'(k);
        step();
        chk("rd_req_read", bmem_read, 1);
        chk("rd_req_addr", bmem_addr, exp_addr);
        step();
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = base + 64'(k);
            bmem_raddr  = (bad_raddr && k == 0) ? 32'h0000_2000 : exp_addr;
            step();
        end
        bmem_rvalid = 1'b0;
        chk("rd_resp_i", i_resp, exp_i);
        chk("rd_resp_d", d_resp, !exp_i);
        chk("rd_line", exp_i ? i_rdata : d_rdata, exp_line);
        if (exp_i) i_read = 1'b0; else d_read = 1'b0;
        step();
        chk("rd_resp_clear", {i_resp, d_resp}, 0);
        if (rearm) begin
            i_read = 1'b1;
            d_read = 1'b1;
        end
    endtask

    initial begin
        logic [255:0] wd;
        logic [255:0] exp_line;
        int resp_before;

        rst_n = 1'b0;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_bmem_read", bmem_read, 0);
        chk("rst_bmem_write", bmem_write, 0);
        chk("rst_bmem_addr", bmem_addr, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_prot_err", prot_err, 0);

        // icache read, 2 idle cycles in RD_DATA before the beats
        i_addr = 32'h0000_1004; i_read = 1'b1; bmem_ready = 1'b1;
        step();
        chk("t1_read", bmem_read, 1);
        chk("t1_addr", bmem_addr, 32'h0000_1000);
        step();
        chk("t1_read_dropped", bmem_read, 0);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_1000;
            bmem_rdata  = {8{8'(8'h11 * (k + 1))}};
            step();
        end
        bmem_rvalid = 1'b0;
        exp_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        chk("t1_i_resp", i_resp, 1);
        chk("t1_d_resp", d_resp, 0);
        chk("t1_i_rdata", i_rdata, exp_line);
        i_read = 1'b0;
        step();
        chk("t1_i_resp_pulse", i_resp, 0);
        chk("t1_i_resp_cnt", 256'(i_resp_cnt), 1);
        chk("t1_d_resp_cnt", 256'(d_resp_cnt), 0);
        chk("t1_read_cycles", 256'(rd_cmd_cnt), 1);
        chk("t1_prot_err", prot_err, 0);

        // dcache writeback, ready always 1
        wd = {64'hDEADBEEF_0000_0003, 64'hDEADBEEF_0000_0002,
              64'hDEADBEEF_0000_0001, 64'hDEADBEEF_0000_0000};
        d_addr = 32'h8000_0040; d_wdata = wd; d_write = 1'b1; bmem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_write", bmem_write, 1);
            chk("t2_addr", bmem_addr, 32'h8000_0040);
            chk("t2_wdata", bmem_wdata, wd[k*64 +: 64]);
            chk("t2_no_early_resp", d_resp, 0);
        end
        step();
        chk("t2_d_resp_cycle5", d_resp, 1);
        chk("t2_write_done", bmem_write, 0);
        d_write = 1'b0;
        step();
        chk("t2_d_resp_pulse", d_resp, 0);

        // Writeback with two 2-cycle stalls
        acc_q.delete();
        wd = {64'hCAFE_0000_0000_0033, 64'hCAFE_0000_0000_0022,
              64'hCAFE_0000_0000_0011, 64'hCAFE_0000_0000_0000};
        d_addr = 32'h8000_0080; d_wdata = wd; d_write = 1'b1; bmem_ready = 1'b1;
        step();
        chk("t3_b0", bmem_wdata, wd[63:0]);
        step(); bmem_ready = 1'b0;
        chk("t3_b1_stall_a", bmem_wdata, wd[127:64]);
        step();
        chk("t3_b1_stall_b", bmem_wdata, wd[127:64]);
        step(); bmem_ready = 1'b1;
        chk("t3_b1_accept", bmem_wdata, wd[127:64]);
        step(); bmem_ready = 1'b0;
        chk("t3_b2_stall_a", bmem_wdata, wd[191:128]);
        step();
        chk("t3_b2_stall_b", bmem_wdata, wd[191:128]);
        step(); bmem_ready = 1'b1;
        chk("t3_b2_accept", bmem_wdata, wd[191:128]);
        step();
        chk("t3_b3", bmem_wdata, wd[255:192]);
        step();
        chk("t3_d_resp", d_resp, 1);
        d_write = 1'b0;
        step();
        chk("t3_accepted", 256'(acc_q.size()), 4);
        for (int k = 0; k < 4; k++) chk("t3_beat_order", acc_q[k], wd[k*64 +: 64]);

        // Round robin after a fresh reset: I, D, I
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        i_addr = 32'h0000_3010; d_addr = 32'h0000_4024;
        i_read = 1'b1; d_read = 1'b1;
        read_line(1'b1, 32'h0000_3000, 64'hA000_0000_0000_0000, 1'b0, 1'b1);
        read_line(1'b0, 32'h0000_4020, 64'hB000_0000_0000_0000, 1'b0, 1'b1);
        read_line(1'b1, 32'h0000_3000, 64'hC000_0000_0000_0000, 1'b0, 1'b0);
        d_read = 1'b0;
        step();

        // Reset in RD_DATA after two beats, then a clean read
        resp_before = i_resp_cnt;
        i_addr = 32'h0000_5000; i_read = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_5000;
            bmem_rdata  = 64'hEEEE_0000_0000_0000 + 64'(k);
            step();
        end
        bmem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_read", bmem_read, 0);
        chk("t5_rst_write", bmem_write, 0);
        chk("t5_rst_addr", bmem_addr, 0);
        chk("t5_rst_resp", {i_resp, d_resp}, 0);
        chk("t5_rst_rdata", i_rdata, 0);
        step();
        rst_n = 1'b1;
        read_line(1'b1, 32'h0000_5000, 64'h5555_0000_0000_0000, 1'b0, 1'b0);
        chk("t5_single_resp", 256'(i_resp_cnt), 256'(resp_before + 1));

        // Mis-tagged read beat, then rvalid while idle
        i_addr = 32'h0000_1000; i_read = 1'b1;
        read_line(1'b1, 32'h0000_1000, 64'h7777_0000_0000_0000, 1'b1, 1'b0);
        chk("t6_prot_err_set", prot_err, FEAT);
        step();
        step();
        chk("t6_prot_err_sticky", prot_err, FEAT);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_prot_err_reset", prot_err, 0);
        resp_before = i_resp_cnt;
        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1000; bmem_rdata = 64'h1;
        step();
        bmem_rvalid = 1'b0;
        step();
        chk("t6_idle_rvalid_read", bmem_read, 0);
        chk("t6_idle_rvalid_resp", 256'(i_resp_cnt), 256'(resp_before));
        chk("t6_idle_rvalid_err", prot_err, FEAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
